// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_ODD   = 2'd1,
    PAR_EVEN  = 2'd2,
    PAR_NONE3 = 2'd3
  } parity_t;

  localparam int OVS_DEFAULT = 16;

  // Data-bits request is clamped into [DATA_BITS_MIN, DATA_W].
  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd9;

  // stop_bits codes at or above this value select two stop bits.
  localparam logic [1:0] STOP_TWO_CODE = 2'd2;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    logic [3:0] r;
    r = req;
    if (req < DATA_BITS_MIN)  r = DATA_BITS_MIN;
    else if (req > max_bits)  r = max_bits;
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// Fractional baud tick generator: emits OVS ticks per bit period from
// the clk_freq/uart_baud pair. Free-running, shared with the transmitter.
module uart_baud_nco #(
  parameter int CLK_W  = 26,
  parameter int BAUD_W = 20,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CLK_W-1:0]  clk_freq,
  input  logic [BAUD_W-1:0] uart_baud,
  output logic              tick
);

  localparam int OVS_LG = $clog2(OVS);
  // One headroom bit above the larger operand so acc+inc never wraps.
  localparam int AW = ((CLK_W > BAUD_W + OVS_LG) ? CLK_W : BAUD_W + OVS_LG) + 1;

  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] inc, freq, sum;

  // Phase accumulate; saturate to a tick every cycle when the rate is unreachable.
  always_comb begin
    inc   = AW'(uart_baud) << OVS_LG;
    freq  = AW'(clk_freq);
    sum   = acc_q + inc;
    tick  = 1'b0;
    acc_d = sum;
    if ((freq == '0) || (inc >= freq)) begin
      tick  = 1'b1;
      acc_d = '0;
    end else if (sum >= freq) begin
      tick  = 1'b1;
      acc_d = sum - freq;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 16x oversampling with 3-sample
// majority vote, optional parity, 1/2 stop bits, parity/framing/break flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CLK_W  = 26,
  parameter int BAUD_W = 20,
  parameter int OVS    = OVS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_serial,
  input  logic [3:0]        data_bits_rx,
  input  logic [1:0]        stop_bits_rx,
  input  logic [1:0]        parity_mode_rx,
  input  logic [CLK_W-1:0]  clk_freq,
  input  logic [BAUD_W-1:0] uart_baud,
  output logic [DATA_W-1:0] rx_parallel,
  output logic              rx_data_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_break,
  output logic              rx_busy
);

  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] OS_S0  = OW'(OVS/2 - 1);
  localparam logic [OW-1:0] OS_S1  = OW'(OVS/2);
  localparam logic [OW-1:0] OS_DEC = OW'(OVS/2 + 1);
  localparam logic [OW-1:0] OS_END = OW'(OVS - 1);

  logic tick;

  uart_baud_nco #(.CLK_W(CLK_W), .BAUD_W(BAUD_W), .OVS(OVS)) u_nco (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_freq  (clk_freq),
    .uart_baud (uart_baud),
    .tick      (tick)
  );

  // [0],[1] form the synchroniser; [2] is the previous synchronised value for edge detect.
  logic [2:0] sync_q;
  logic       rx_s, fall;

  // Synchroniser chain, idle-high reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], rx_serial};
  end

  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

  rx_state_t         state_q, state_d;
  logic [OW-1:0]     os_q, os_d;
  logic [1:0]        smp_q, smp_d;
  logic [3:0]        nbits_q, nbits_d;
  logic              two_stop_q, two_stop_d;
  parity_t           par_q, par_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic              scnt_q, scnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              xor_q, xor_d;
  logic              zero_q, zero_d;   // every frame bit so far was 0
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              operr_q, operr_d;
  logic              oferr_q, oferr_d;
  logic              valid_q, valid_d;
  logic              brk_q, brk_d;

  logic maj, dec, eob, par_en, exp_par, ferr_n, zero_n;

  // Majority of the two stored mid-bit samples and the current one.
  assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign dec    = tick && (os_q == OS_DEC);
  assign eob    = tick && (os_q == OS_END);
  assign par_en = (par_q == PAR_ODD) || (par_q == PAR_EVEN);

  // Receive FSM next-state and datapath.
  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    smp_d      = smp_q;
    nbits_d    = nbits_q;
    two_stop_d = two_stop_q;
    par_d      = par_q;
    bcnt_d     = bcnt_q;
    scnt_d     = scnt_q;
    sh_d       = sh_q;
    xor_d      = xor_q;
    zero_d     = zero_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    operr_d    = operr_q;
    oferr_d    = oferr_q;
    valid_d    = 1'b0;
    brk_d      = 1'b0;
    exp_par    = (par_q == PAR_EVEN) ? xor_q : ~xor_q;
    ferr_n     = ferr_q | ~maj;
    zero_n     = zero_q & ~maj;

    if ((state_q != ST_IDLE) && tick) begin
      os_d = os_q + 1'b1;
      if (os_q == OS_S0) smp_d[0] = rx_s;
      if (os_q == OS_S1) smp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          nbits_d    = clamp_data_bits(data_bits_rx, 4'(DATA_W));
          two_stop_d = (stop_bits_rx >= STOP_TWO_CODE);
          par_d      = parity_t'(parity_mode_rx);
          os_d       = '0;
          sh_d       = '0;
          bcnt_d     = '0;
          scnt_d     = 1'b0;
          xor_d      = 1'b0;
          zero_d     = 1'b1;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (dec && maj)  state_d = ST_IDLE;
        else if (eob)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (dec) begin
          for (int i = 0; i < DATA_W; i++)
            if (bcnt_q == 4'(i)) sh_d[i] = maj;
          xor_d  = xor_q ^ maj;
          zero_d = zero_n;
        end
        if (eob) begin
          if (bcnt_q == nbits_q - 4'd1) state_d = par_en ? ST_PARITY : ST_STOP;
          else                          bcnt_d  = bcnt_q + 4'd1;
        end
      end
      ST_PARITY: begin
        if (dec) begin
          perr_d = (maj != exp_par);
          zero_d = zero_n;
        end
        if (eob) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (dec) begin
          if (scnt_q == two_stop_q) begin
            // Last stop decision: leave mid-bit so the next start edge is caught.
            if (zero_n) begin
              brk_d   = 1'b1;
              state_d = ST_BREAK;
            end else begin
              valid_d = 1'b1;
              data_d  = sh_q;
              operr_d = perr_q;
              oferr_d = ferr_n;
              state_d = ST_IDLE;
            end
          end else begin
            ferr_d = ferr_n;
            zero_d = zero_n;
          end
        end
        if (eob) scnt_d = 1'b1;
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      os_q       <= '0;
      smp_q      <= 2'b11;
      nbits_q    <= 4'(DATA_W);
      two_stop_q <= 1'b0;
      par_q      <= PAR_NONE;
      bcnt_q     <= '0;
      scnt_q     <= 1'b0;
      sh_q       <= '0;
      xor_q      <= 1'b0;
      zero_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      operr_q    <= 1'b0;
      oferr_q    <= 1'b0;
      valid_q    <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_q       <= os_d;
      smp_q      <= smp_d;
      nbits_q    <= nbits_d;
      two_stop_q <= two_stop_d;
      par_q      <= par_d;
      bcnt_q     <= bcnt_d;
      scnt_q     <= scnt_d;
      sh_q       <= sh_d;
      xor_q      <= xor_d;
      zero_q     <= zero_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      operr_q    <= operr_d;
      oferr_q    <= oferr_d;
      valid_q    <= valid_d;
      brk_q      <= brk_d;
    end
  end

  assign rx_parallel   = data_q;
  assign rx_parity_err = operr_q;
  assign rx_frame_err  = oferr_q;
  assign rx_data_valid = valid_q;
  assign rx_break      = brk_q;
  assign rx_busy       = (state_q != ST_IDLE);

endmodule
